// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU front-end for a 32-bit unsigned multi-cycle divider.
// Optional result reuse cache enabled by defining DIV_SEQ_RESULT_CACHE_EN.
module div_sequencer #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             div_start,
    input  logic             div_ready,
    input  logic             div_valid,
    input  logic             div_error,
    output logic [31:0]      div_dividend,
    output logic [31:0]      div_divisor,
    input  logic [31:0]      div_quotient,
    input  logic [31:0]      div_remainder
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    state_t state, state_next;

    function automatic logic [31:0] negate_if(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    logic        accept;
    logic        req_signed;
    logic        req_rem;
    logic        a_neg;
    logic        b_neg;
    logic        special;
    logic        cache_hit;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] special_result;
    logic [31:0] cache_result;
    logic [31:0] div_result;
    logic [31:0] orig_a;
    logic        signed_q;
    logic        rem_q;
    logic        sign_q;
    logic        sign_r;

    assign accept     = req_valid && req_ready;
    assign req_signed = ~req_op[0];
    assign req_rem    = req_op[1];
    assign a_neg      = req_signed & req_a[31];
    assign b_neg      = req_signed & req_b[31];
    assign abs_a      = negate_if(req_a, a_neg);
    assign abs_b      = negate_if(req_b, b_neg);

    assign special = (req_b == 32'd0) ||
                     (req_signed && (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF));

    assign special_result = (req_b == 32'd0) ? (req_rem ? req_a : 32'hFFFF_FFFF)
                                             : (req_rem ? 32'd0 : 32'h8000_0000);

    // The original dividend is rebuilt from the stored magnitude for the divide-by-zero fallback.
    assign orig_a = negate_if(div_dividend, signed_q & sign_r);

    assign div_result = div_error ? (rem_q ? orig_a : 32'hFFFF_FFFF)
                      : rem_q     ? negate_if(div_remainder, signed_q & sign_r)
                                  : negate_if(div_quotient, signed_q & sign_q);

`ifdef DIV_SEQ_RESULT_CACHE_EN
    logic        c_valid;
    logic        c_signed;
    logic [31:0] c_a;
    logic [31:0] c_b;
    logic [31:0] c_q;
    logic [31:0] c_r;

    assign cache_hit    = c_valid && (c_a == abs_a) && (c_b == abs_b) && (c_signed == req_signed);
    assign cache_result = req_rem ? negate_if(c_r, a_neg) : negate_if(c_q, a_neg ^ b_neg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid  <= 1'b0;
            c_signed <= 1'b0;
            c_a      <= '0;
            c_b      <= '0;
            c_q      <= '0;
            c_r      <= '0;
        end else if (kill && (state == WAIT || state == DRAIN)) begin
            c_valid <= 1'b0;
        end else if (state == WAIT && div_valid && !div_error) begin
            c_valid  <= 1'b1;
            c_signed <= signed_q;
            c_a      <= div_dividend;
            c_b      <= div_divisor;
            c_q      <= div_quotient;
            c_r      <= div_remainder;
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        div_start  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !kill;
                if (accept) begin
                    state_next = (special || cache_hit) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_start = !kill;
                if (kill) begin
                    state_next = IDLE;
                end else if (div_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (kill) begin
                    state_next = div_valid ? IDLE : DRAIN;
                end else if (div_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (kill || resp_ready) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (div_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture at accept and result capture when the response becomes ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signed_q     <= 1'b0;
            rem_q        <= 1'b0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            resp_data    <= '0;
            resp_tag     <= '0;
        end else if (state == IDLE && accept) begin
            signed_q <= req_signed;
            rem_q    <= req_rem;
            sign_q   <= a_neg ^ b_neg;
            sign_r   <= a_neg;
            resp_tag <= req_tag;
            if (special) begin
                resp_data <= special_result;
            end else if (cache_hit) begin
                resp_data <= cache_result;
            end else begin
                div_dividend <= abs_a;
                div_divisor  <= abs_b;
            end
        end else if (state == WAIT && div_valid && !kill) begin
            resp_data <= div_result;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized self-checking bench for div_sequencer with a behavioural divider and reference model.
// Cache-hit latency expectations follow DIV_SEQ_RESULT_CACHE_EN.
module tb_div_sequencer;

    localparam int TAG_W = 5;
`ifdef DIV_SEQ_RESULT_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             kill = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             div_start;
    logic             div_ready;
    logic             div_valid;
    logic             div_error;
    logic [31:0]      div_dividend;
    logic [31:0]      div_divisor;
    logic [31:0]      div_quotient;
    logic [31:0]      div_remainder;

    div_sequencer #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .kill(kill),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag),
        .div_start(div_start), .div_ready(div_ready), .div_valid(div_valid),
        .div_error(div_error), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference expectations for the transaction in flight
    bit          exp_pending = 1'b0;
    bit          exp_uses_div = 1'b0;
    logic [31:0] exp_data = '0;
    logic [31:0] exp_tag = '0;
    logic [31:0] exp_mag_a = '0;
    logic [31:0] exp_mag_b = '0;

    // Model of the result cache contents
    bit          c_valid = 1'b0;
    bit          c_signed = 1'b0;
    logic [31:0] c_a = '0;
    logic [31:0] c_b = '0;

    // Behavioural divider: 1 cycle when divisor > dividend, else 33 cycles
    bit          rand_rdy_en = 1'b1;
    logic        busy;
    logic        rdy_rand;
    int          cnt;

    assign div_ready = !busy && rdy_rand;
    assign div_error = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            div_valid     <= 1'b0;
            cnt           <= 0;
            div_quotient  <= '0;
            div_remainder <= '0;
            rdy_rand      <= 1'b1;
        end else begin
            div_valid <= 1'b0;
            rdy_rand  <= rand_rdy_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (busy) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    div_valid <= 1'b1;
                    busy      <= 1'b0;
                end
            end else if (div_start && div_ready) begin
                div_quotient  <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
                div_remainder <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
                if (div_divisor > div_dividend) begin
                    div_valid <= 1'b1;
                end else begin
                    busy <= 1'b1;
                    cnt  <= 32;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] magnitude(input logic [1:0] op, input logic [31:0] x);
        if (!op[0] && $signed(x) < 0) return 32'(-$signed(x));
        return x;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        bit ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00:   return ovf ? 32'h8000_0000 : 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return ovf ? 32'd0 : 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 20));
            2:       return 32'd0;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return 32'(-$urandom_range(1, 20));
        endcase
    endfunction

    // Every cycle: any response must match the model, and any divider start must carry the magnitudes
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                checkOutput("resp_expected", 32'(exp_pending), 32'd1);
                if (exp_pending) begin
                    checkOutput("resp_data", resp_data, exp_data);
                    checkOutput("resp_tag", 32'(resp_tag), exp_tag);
                    checkOutput("ready_in_resp", 32'(req_ready), 32'd0);
                end
            end
            if (div_start) begin
                checkOutput("start_expected", 32'(exp_uses_div), 32'd1);
                checkOutput("div_dividend", div_dividend, exp_mag_a);
                checkOutput("div_divisor", div_divisor, exp_mag_b);
            end
        end
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        @(posedge clk);
        #1;
        while (!req_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!req_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] tag, input int stall, input bit kill_in_resp,
                                 output logic [31:0] got);
        bit special;
        bit hit;
        int lat;
        got = 'x;
        wait_ready();
        special      = is_special(op, a, b);
        hit          = CACHE_EN && !special && c_valid && c_signed == !op[0] &&
                       c_a == magnitude(op, a) && c_b == magnitude(op, b);
        exp_data     = ref_result(op, a, b);
        exp_tag      = 32'(tag);
        exp_uses_div = !special && !hit;
        exp_mag_a    = magnitude(op, a);
        exp_mag_b    = magnitude(op, b);
        exp_pending  = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 120);
        if (!resp_valid) begin
            checkOutput("resp_timeout", 32'd0, 32'd1);
            exp_pending = 1'b0;
            return;
        end
        got = resp_data;
        if (special || hit) checkOutput("fast_latency", 32'(lat), 32'd1);
        else                checkOutput("div_latency_min", 32'(lat >= 3), 32'd1);
        if (exp_uses_div) begin
            c_valid  = 1'b1;
            c_signed = !op[0];
            c_a      = exp_mag_a;
            c_b      = exp_mag_b;
        end
        repeat (stall) @(posedge clk);
        #1;
        if (kill_in_resp) kill = 1'b1;
        else              resp_ready = 1'b1;
        @(posedge clk);
        exp_pending  = 1'b0;
        exp_uses_div = 1'b0;
        #1;
        kill       = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("resp_drop", 32'(resp_valid), 32'd0);
    endtask

    // Long DIVU killed mid-run: the sequencer must drain the divider before accepting again
    task automatic runKill();
        int guard;
        rand_rdy_en = 1'b0;
        wait_ready();
        exp_uses_div = 1'b1;
        exp_mag_a    = 32'hFFFF_FFFF;
        exp_mag_b    = 32'd1;
        exp_pending  = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'hFFFF_FFFF;
        req_b     = 32'd1;
        req_tag   = 5'd9;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        guard = 0;
        while (!div_start && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("kill_saw_start", 32'(div_start), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        exp_pending  = 1'b0;
        exp_uses_div = 1'b0;
        c_valid      = 1'b0;
        #1;
        kill = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            checkOutput("drain_ready", 32'(req_ready), 32'd0);
            guard++;
        end while (!div_valid && guard < 60);
        checkOutput("drain_saw_valid", 32'(div_valid), 32'd1);
        @(negedge clk);
        checkOutput("drain_exit_ready", 32'(req_ready), 32'd1);
        rand_rdy_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        checkOutput("rst_resp_tag", 32'(resp_tag), 32'd0);
        checkOutput("rst_div_start", 32'(div_start), 32'd0);
        checkOutput("rst_dividend", div_dividend, 32'd0);
        checkOutput("rst_divisor", div_divisor, 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);

        #1;
        kill = 1'b1;
        #1;
        checkOutput("kill_blocks_ready", 32'(req_ready), 32'd0);
        kill = 1'b0;

        applyStimulus(2'b01, 32'd100, 32'd7, 5'd3, 0, 1'b0, got);
        checkOutput("lit_divu_100_7", got, 32'd14);
        applyStimulus(2'b11, 32'd100, 32'd7, 5'd4, 0, 1'b0, got);
        checkOutput("lit_remu_100_7", got, 32'd2);
        applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 1, 1'b0, got);
        checkOutput("lit_div_m7_2", got, 32'hFFFF_FFFD);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 1'b0, got);
        checkOutput("lit_rem_m7_2", got, 32'hFFFF_FFFF);
        applyStimulus(2'b00, 32'd5, 32'd0, 5'd7, 0, 1'b0, got);
        checkOutput("lit_div_by_zero", got, 32'hFFFF_FFFF);
        applyStimulus(2'b11, 32'd5, 32'd0, 5'd8, 0, 1'b0, got);
        checkOutput("lit_remu_by_zero", got, 32'd5);
        applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 1'b0, got);
        checkOutput("lit_div_overflow", got, 32'h8000_0000);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 1'b0, got);
        checkOutput("lit_rem_overflow", got, 32'd0);

        runKill();
        applyStimulus(2'b01, 32'd1000, 32'd3, 5'd12, 10, 1'b0, got);
        checkOutput("lit_after_kill_stall", got, 32'd333);

        applyStimulus(2'b00, 32'd100, 32'd7, 5'd13, 0, 1'b0, got);
        checkOutput("lit_div_100_7", got, 32'd14);
        applyStimulus(2'b10, 32'd100, 32'd7, 5'd14, 0, 1'b0, got);
        checkOutput("lit_rem_100_7", got, 32'd2);

        applyStimulus(2'b00, 32'd50, 32'd9, 5'd15, 2, 1'b1, got);

        for (int i = 0; i < 80; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            applyStimulus(op, a, b, 5'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
